dcache_miss_repair_unit: RTL and testbench
==========================================

// Module: dcache_miss_repair_unit
// PURPOSE
//  Services data-cache read misses on the arbiter side of the controller/arbiter interface.
//  - Latches the controller's read_repair_request and missed_addr.
//  - Fetches the block-aligned line from memory as BEATS narrow beats and assembles a full line.
//  - Returns the line to the dCache controller as a full-mask write.
//  - Signals completion with repair_resolved.
//  - One outstanding miss at a time.
// PARAMETERS
//  ADDR_W      32    address width
//  BLOCK_BITS  1024  cache line width in bits (128 bytes)
//  MEM_DATA_W  32    memory response beat width; BEATS = BLOCK_BITS/MEM_DATA_W (32)
// PORTS
//  clk                  in   1             clock, rising edge
//  rst                  in   1             synchronous reset, active-high
//  read_repair_request  in   1             controller requests miss repair (level)
//  missed_addr          in   ADDR_W        missed byte address, valid with request
//  mem_req_valid        out  1             memory read request valid
//  mem_req_ready        in   1             memory accepts request
//  mem_req_addr         out  ADDR_W        line-aligned address (low log2(BLOCK_BITS/8) bits = 0)
//  mem_resp_valid       in   1             one beat of response data valid
//  mem_resp_data        in   MEM_DATA_W    response beat
//  waddr_valid          out  1             repair write to controller valid
//  waddr                out  ADDR_W        repair address (= latched missed_addr, unmodified)
//  wdata                out  BLOCK_BITS    assembled line
//  wmask                out  BLOCK_BITS/8  byte write mask (all ones during repair)
//  sent_repair          out  1             repair line presented this cycle
//  repair_resolved      out  1             repair complete, one-cycle pulse
//  busy                 out  1             high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, beat_cnt=0, req_seen=0; all outputs 0, wdata=0, wmask=0.
//  Reset mid-operation: abandons the miss; later mem_resp beats are ignored until a new REQ.
//  States and transitions:
//  - IDLE: if read_repair_request && !req_seen, latch missed_addr, set req_seen, clear line buffer
//    and beat_cnt, then go to REQ.
//  - REQ: mem_req_valid=1, mem_req_addr=aligned latched addr.
//    - Address is held stable until mem_req_valid && mem_req_ready.
//    - Then go to FILL.
//    - mem_resp_valid in REQ is ignored.
//  - FILL: each cycle with mem_resp_valid:
//    - writes mem_resp_data into line[beat_cnt*MEM_DATA_W +: MEM_DATA_W] and increments beat_cnt.
//    - Beat 0 fills the least-significant word.
//    - On beat BEATS-1, go to SEND; beat_cnt wraps to 0.
//    - Gaps between beats (mem_resp_valid=0) are allowed with no timeout.
//  - SEND (exactly 1 cycle): waddr_valid=1, sent_repair=1, waddr=latched addr, wdata=line,
//    wmask=all ones. Then go to RESOLVE.
//  - RESOLVE (exactly 1 cycle): repair_resolved=1; waddr_valid=0, sent_repair=0, wmask=0.
//    wdata keeps the line value. Then go to IDLE.
//  Request re-arm:
//  - req_seen clears in any cycle in which read_repair_request=0.
//  - A request held high across RESOLVE does not start a second fill.
//  - The controller must drop the request for at least 1 cycle before the next miss.
//  - Requests arriving outside IDLE are ignored and are not queued.
//  Latency: request seen in IDLE (cycle 0); mem_req_valid from cycle 1.
//  - With ready=1 and back-to-back beats starting the cycle after acceptance, SEND occurs in
//    cycle 2+BEATS and RESOLVE in cycle 3+BEATS.
//  Outputs are registered or decoded from state only; there is no combinational path from
//  memory inputs to controller outputs.
// TESTING
//  1. Reset: rst=1 for 2 cycles, mid-FILL -> all outputs 0, state IDLE; stray mem_resp_valid
//     produces no sent_repair.
//  2. Basic miss: request with missed_addr=32'hAABB_CCDD -> mem_req_addr=32'hAABB_CC80.
//     - Feed 32 beats, beat k = {8{k[3:0]}}.
//     - Expect SEND: waddr=32'hAABB_CCDD, wdata[31:0]=0, wdata[1023:992]=32'hFFFF_FFFF,
//       wmask all ones.
//     - Expect repair_resolved on the next cycle.
//  3. Backpressure: mem_req_ready=0 for 5 cycles -> mem_req_valid and mem_req_addr stable
//     throughout; fill starts only after acceptance.
//  4. Gapped beats: mem_resp_valid toggled every other cycle -> same assembled line as
//     scenario 2; SEND only after beat 31.
//  5. Held request: read_repair_request held high through RESOLVE plus 3 cycles ->
//     exactly one mem request.
//     - Drop for 1 cycle and raise with missed_addr=32'h0000_1004.
//     - Expect a new mem request with mem_req_addr=32'h0000_1000.
//  6. Busy-time request: request toggled during FILL -> ignored; busy=1 from REQ to RESOLVE
//     inclusive, 0 in IDLE.

Source files
------------

// File: rtl/dcache_miss_repair_unit.sv
// Data-cache miss repair: fetches one line from memory as narrow beats
// and hands it back to the dCache controller as a full-mask write.
module dcache_miss_repair_unit #(
  parameter int ADDR_W     = 32,
  parameter int BLOCK_BITS = 1024,
  parameter int MEM_DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    read_repair_request,
  input  logic [ADDR_W-1:0]       missed_addr,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_W-1:0]       mem_req_addr,
  input  logic                    mem_resp_valid,
  input  logic [MEM_DATA_W-1:0]   mem_resp_data,
  output logic                    waddr_valid,
  output logic [ADDR_W-1:0]       waddr,
  output logic [BLOCK_BITS-1:0]   wdata,
  output logic [BLOCK_BITS/8-1:0] wmask,
  output logic                    sent_repair,
  output logic                    repair_resolved,
  output logic                    busy
);

  localparam int BEATS  = BLOCK_BITS / MEM_DATA_W;
  localparam int CNT_W  = $clog2(BEATS);
  localparam int OFF_W  = $clog2(BLOCK_BITS / 8);
  localparam int MASK_W = BLOCK_BITS / 8;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_FILL,
    S_SEND,
    S_RESOLVE
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      beat_cnt;
  logic                  req_seen;
  logic [BLOCK_BITS-1:0] line;

  // The line buffer doubles as the write-data register.
  assign wdata = line;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      beat_cnt        <= '0;
      req_seen        <= 1'b0;
      line            <= '0;
      mem_req_valid   <= 1'b0;
      mem_req_addr    <= '0;
      waddr_valid     <= 1'b0;
      waddr           <= '0;
      wmask           <= '0;
      sent_repair     <= 1'b0;
      repair_resolved <= 1'b0;
      busy            <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (read_repair_request && !req_seen) begin
            state         <= S_REQ;
            req_seen      <= 1'b1;
            waddr         <= missed_addr;
            mem_req_addr  <= {missed_addr[ADDR_W-1:OFF_W],
                              {OFF_W{1'b0}}};
            line          <= '0;
            beat_cnt      <= '0;
            mem_req_valid <= 1'b1;
            busy          <= 1'b1;
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            state         <= S_FILL;
            mem_req_valid <= 1'b0;
          end
        end
        S_FILL: begin
          if (mem_resp_valid) begin
            line[int'(beat_cnt)*MEM_DATA_W +: MEM_DATA_W]
              <= mem_resp_data;
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt    <= '0;
              state       <= S_SEND;
              waddr_valid <= 1'b1;
              sent_repair <= 1'b1;
              wmask       <= {MASK_W{1'b1}};
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        S_SEND: begin
          state           <= S_RESOLVE;
          waddr_valid     <= 1'b0;
          sent_repair     <= 1'b0;
          wmask           <= '0;
          repair_resolved <= 1'b1;
        end
        S_RESOLVE: begin
          state           <= S_IDLE;
          repair_resolved <= 1'b0;
          busy            <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      // A level request must drop before it can start another miss.
      if (!read_repair_request) begin
        req_seen <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dcache_miss_repair_unit.sv
// Scoreboard bench for dcache_miss_repair_unit: directed misses with
// queued expectations checked by a negedge monitor.
module tb_dcache_miss_repair_unit;

  localparam int AW = 32;
  localparam int BB = 1024;
  localparam int DW = 32;
  localparam int NB = BB / DW;
  localparam int MW = BB / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          read_repair_request = 1'b0;
  logic [AW-1:0] missed_addr = '0;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b1;
  logic [AW-1:0] mem_req_addr;
  logic          mem_resp_valid = 1'b0;
  logic [DW-1:0] mem_resp_data = '0;
  logic          waddr_valid;
  logic [AW-1:0] waddr;
  logic [BB-1:0] wdata;
  logic [MW-1:0] wmask;
  logic          sent_repair;
  logic          repair_resolved;
  logic          busy;

  dcache_miss_repair_unit #(
    .ADDR_W(AW),
    .BLOCK_BITS(BB),
    .MEM_DATA_W(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .read_repair_request(read_repair_request),
    .missed_addr(missed_addr),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data),
    .waddr_valid(waddr_valid),
    .waddr(waddr),
    .wdata(wdata),
    .wmask(wmask),
    .sent_repair(sent_repair),
    .repair_resolved(repair_resolved),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int sent_cnt = 0;
  int acc_cnt = 0;
  bit prev_sent = 1'b0;

  logic [AW-1:0] exp_mem[$];
  logic [AW-1:0] exp_waddr[$];
  logic [BB-1:0] exp_line[$];
  logic [AW-1:0] mon_a;
  logic [BB-1:0] mon_l;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: event occurred, none required", nm);
  endtask

  function automatic logic [DW-1:0] beat(input int k);
    logic [3:0] n;
    n = k[3:0];
    return {8{n}};
  endfunction

  function automatic logic [BB-1:0] pat_line();
    logic [BB-1:0] l;
    l = '0;
    for (int k = 0; k < NB; k++) l[k*DW +: DW] = beat(k);
    return l;
  endfunction

  // Monitor: compares every accepted mem request and every repair.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req_valid && mem_req_ready) begin
        acc_cnt++;
        if (exp_mem.size() == 0) flag("mem_req_extra");
        else chk("mem_req_addr", mem_req_addr, exp_mem.pop_front());
      end
      if (sent_repair) begin
        sent_cnt++;
        if (exp_waddr.size() == 0) begin
          flag("repair_extra");
        end else begin
          mon_a = exp_waddr.pop_front();
          mon_l = exp_line.pop_front();
          chk("waddr", waddr, mon_a);
          chk("waddr_valid", waddr_valid, 1);
          chk("wmask_ones", wmask == {MW{1'b1}}, 1);
          chk("wdata_line", wdata == mon_l, 1);
          chk("wdata_lo", wdata[31:0], mon_l[31:0]);
          chk("wdata_hi", wdata[BB-1:BB-32], mon_l[BB-1:BB-32]);
        end
      end
      if (repair_resolved) chk("resolve_after_send", prev_sent, 1);
      prev_sent = sent_repair;
    end else begin
      prev_sent = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_outs(input string tag);
    chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
    chk({tag, "_mem_req_addr"}, mem_req_addr, 0);
    chk({tag, "_waddr_valid"}, waddr_valid, 0);
    chk({tag, "_waddr"}, waddr, 0);
    chk({tag, "_wdata0"}, wdata == '0, 1);
    chk({tag, "_wmask0"}, wmask == '0, 1);
    chk({tag, "_sent"}, sent_repair, 0);
    chk({tag, "_resolved"}, repair_resolved, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic run_miss(input logic [AW-1:0] a, input int stall,
                          input bit gap, input bit hold,
                          input bit toggle);
    logic [AW-1:0] al;
    int n;
    al = {a[AW-1:7], 7'b0};
    exp_mem.push_back(al);
    exp_waddr.push_back(a);
    exp_line.push_back(pat_line());
    read_repair_request = 1'b1;
    missed_addr = a;
    tick();
    if (!hold) begin
      read_repair_request = 1'b0;
      missed_addr = 32'h7777_7777;
    end
    chk("req_valid", mem_req_valid, 1);
    chk("req_addr_now", mem_req_addr, al);
    chk("busy_req", busy, 1);
    if (stall > 0) begin
      mem_req_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'hDEAD_BEEF;
        tick();
        chk("stall_valid", mem_req_valid, 1);
        chk("stall_addr", mem_req_addr, al);
      end
      mem_resp_valid = 1'b0;
      mem_req_ready = 1'b1;
    end
    n = 0;
    while (!(mem_req_valid && mem_req_ready) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) flag("accept_timeout");
    tick();
    for (int k = 0; k < NB; k++) begin
      if (gap) begin
        mem_resp_valid = 1'b0;
        tick();
        chk("no_early_send", sent_repair, 0);
      end
      if (toggle) begin
        read_repair_request = k[0];
        missed_addr = 32'h5555_0000;
        chk("busy_fill", busy, 1);
      end
      mem_resp_valid = 1'b1;
      mem_resp_data = beat(k);
      tick();
    end
    mem_resp_valid = 1'b0;
    if (toggle) read_repair_request = 1'b0;
    chk("sent_repair", sent_repair, 1);
    chk("busy_send", busy, 1);
    chk("send_lo", wdata[31:0], 32'h0);
    chk("send_hi", wdata[BB-1:BB-32], 32'hFFFF_FFFF);
    tick();
    chk("resolved", repair_resolved, 1);
    chk("resolve_wvalid", waddr_valid, 0);
    chk("resolve_sent", sent_repair, 0);
    chk("resolve_wmask0", wmask == '0, 1);
    chk("resolve_wdata", wdata[BB-1:BB-32], 32'hFFFF_FFFF);
    chk("busy_resolve", busy, 1);
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_resolved", repair_resolved, 0);
    if (hold) begin
      repeat (3) tick();
      chk("hold_no_req", mem_req_valid, 0);
      chk("hold_busy", busy, 0);
      read_repair_request = 1'b0;
      tick();
    end
  endtask

  initial begin
    int s0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    zero_outs("reset");

    // Reset in the middle of a fill.
    exp_mem.push_back(32'h0000_2000);
    read_repair_request = 1'b1;
    missed_addr = 32'h0000_2044;
    tick();
    read_repair_request = 1'b0;
    tick();
    for (int k = 0; k < 10; k++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data = beat(k);
      tick();
    end
    chk("busy_midfill", busy, 1);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    zero_outs("midreset");
    s0 = sent_cnt;
    for (int k = 0; k < 40; k++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data = beat(k);
      tick();
    end
    mem_resp_valid = 1'b0;
    chk("stray_no_send", sent_cnt, s0);
    chk("stray_busy", busy, 0);
    chk("stray_wdata0", wdata == '0, 1);

    run_miss(32'hAABB_CCDD, 0, 1'b0, 1'b0, 1'b0);
    run_miss(32'h1234_5678, 5, 1'b0, 1'b0, 1'b0);
    run_miss(32'hCAFE_01FF, 0, 1'b1, 1'b0, 1'b0);
    run_miss(32'h8000_0040, 0, 1'b0, 1'b1, 1'b0);
    run_miss(32'h0000_1004, 0, 1'b0, 1'b0, 1'b0);
    run_miss(32'h0F0F_0F33, 0, 1'b0, 1'b0, 1'b1);

    repeat (5) tick();
    chk("mem_q_empty", exp_mem.size(), 0);
    chk("repair_q_empty", exp_waddr.size(), 0);
    chk("accept_total", acc_cnt, 7);
    chk("sent_total", sent_cnt, 6);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
